// File: rtl/gamepad_pkg.sv
// Shared definitions for the gamepad poll scheduler.
//   poll_state_t : frame sequencer states
//   BTN_*        : canonical button bit positions in the 12-bit words
//   NES_BITS / SNES_BITS : serial frame lengths
//   SNES_MAP     : canonical index of each SNES serial bit (bits 0..11)
//   decode_frame : raw active-low serial bits -> canonical active-high word
package gamepad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_SETTLE,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_DONE
  } poll_state_t;

  localparam int NES_BITS  = 8;
  localparam int SNES_BITS = 16;
  localparam int NUM_BTN   = 12;

  typedef logic [3:0] btn_idx_t;

  localparam btn_idx_t BTN_A     = 4'd0;
  localparam btn_idx_t BTN_B     = 4'd1;
  localparam btn_idx_t BTN_SEL   = 4'd2;
  localparam btn_idx_t BTN_START = 4'd3;
  localparam btn_idx_t BTN_UP    = 4'd4;
  localparam btn_idx_t BTN_DOWN  = 4'd5;
  localparam btn_idx_t BTN_LEFT  = 4'd6;
  localparam btn_idx_t BTN_RIGHT = 4'd7;
  localparam btn_idx_t BTN_X     = 4'd8;
  localparam btn_idx_t BTN_Y     = 4'd9;
  localparam btn_idx_t BTN_L     = 4'd10;
  localparam btn_idx_t BTN_R     = 4'd11;

  localparam btn_idx_t SNES_MAP [NUM_BTN] = '{
    BTN_B, BTN_Y, BTN_SEL, BTN_START, BTN_UP, BTN_DOWN,
    BTN_LEFT, BTN_RIGHT, BTN_A, BTN_X, BTN_L, BTN_R
  };

  // raw[k] is serial bit k (bit 0 = first bit out of the pad).
  // NES serial order already matches canonical order 0..7.
  function automatic logic [NUM_BTN-1:0] decode_frame(input logic [SNES_BITS-1:0] raw,
                                                       input logic snes);
    logic [NUM_BTN-1:0] btn;
    btn = '0;
    if (snes) begin
      for (int k = 0; k < NUM_BTN; k++) btn[SNES_MAP[k]] = ~raw[k];
    end else begin
      for (int k = 0; k < NES_BITS; k++) btn[k] = ~raw[k];
    end
    return btn;
  endfunction

endpackage

// File: rtl/poll_tick_gen.sv
// Poll period divider.
//   clk_50 : system clock
//   rst_n  : async active-low reset
//   tick   : one-cycle pulse every POLL_CYC cycles, free-running
// Counts down from POLL_CYC-1 and ticks at zero, which gives the same tick
// timing as an up-counter wrapping at POLL_CYC-1 (first tick POLL_CYC-1
// cycles after reset release).
module poll_tick_gen #(
  parameter int POLL_CYC = 833_333
) (
  input  logic clk_50,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(POLL_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n)            cnt <= RELOAD;
    else if (cnt == '0)    cnt <= RELOAD;
    else                   cnt <= cnt - 1'b1;
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/gamepad_poll_scheduler.sv
// Shared-bus poller for two NES/SNES pad ports.
//   clk_50, rst_n          : clock, async active-low reset
//   poll_en                : allow new frames to start on poll ticks
//   is_snes                : frame type, captured on entry to LATCH
//   data_p1, data_p2       : serial pad data (active-low buttons)
//   controller_latch/clk   : shared latch (active high) and serial clock (idles high)
//   p1/p2_buttons          : canonical 12-bit active-high button words
//   p1/p2_present          : pad detected in the last frame
//   frame_valid            : one-cycle pulse in DONE, new outputs this cycle
//   busy                   : frame in progress
//   overrun                : sticky, poll tick seen while busy
//
// state     | meaning
// ----------+-----------------------------------------------------
// ST_IDLE   | waiting for poll tick with poll_en
// ST_LATCH  | latch high for 2*HALF_CYC cycles
// ST_SETTLE | latch low HALF_CYC cycles, bit 0 sampled on last cycle
// ST_CLK_LO | serial clock low HALF_CYC cycles
// ST_CLK_HI | serial clock high HALF_CYC cycles, next bit sampled on last cycle
// ST_DONE   | one cycle, outputs published, frame_valid high
module gamepad_poll_scheduler
  import gamepad_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int POLL_HZ  = 60,
  parameter int HALF_CYC = 300
) (
  input  logic                clk_50,
  input  logic                rst_n,
  input  logic                poll_en,
  input  logic                is_snes,
  input  logic                data_p1,
  input  logic                data_p2,
  output logic                controller_latch,
  output logic                controller_clk,
  output logic [NUM_BTN-1:0]  p1_buttons,
  output logic [NUM_BTN-1:0]  p2_buttons,
  output logic                p1_present,
  output logic                p2_present,
  output logic                frame_valid,
  output logic                busy,
  output logic                overrun
);

  localparam int POLL_CYC = CLK_HZ / POLL_HZ;
  localparam int PW = $clog2(2 * HALF_CYC);
  localparam logic [PW-1:0] LATCH_LOAD = PW'(2 * HALF_CYC - 1);
  localparam logic [PW-1:0] HALF_LOAD  = PW'(HALF_CYC - 1);

  poll_state_t state, state_nxt;

  logic                 tick;
  logic [PW-1:0]        phase;
  logic                 phase_tc;
  logic [3:0]           bit_idx;
  logic                 snes_q;
  logic                 sample;
  logic                 last_bit;
  logic                 frame_start;
  logic [SNES_BITS-1:0] raw_p1, raw_p2;
  logic [SNES_BITS-1:0] raw_p1_nxt, raw_p2_nxt;
  logic [SNES_BITS-1:0] aligned_p1, aligned_p2;
  logic                 pres_p1, pres_p2;

  poll_tick_gen #(.POLL_CYC(POLL_CYC)) u_tick (
    .clk_50 (clk_50),
    .rst_n  (rst_n),
    .tick   (tick)
  );

  assign phase_tc    = (phase == '0);
  assign last_bit    = (bit_idx == (snes_q ? 4'd15 : 4'd7));
  assign frame_start = (state == ST_IDLE) && (state_nxt == ST_LATCH);

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    sample           = 1'b0;
    controller_latch = 1'b0;
    controller_clk   = 1'b1;
    case (state)
      ST_IDLE: begin
        if (tick && poll_en) state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        controller_latch = 1'b1;
        if (phase_tc) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (phase_tc) begin
          sample    = 1'b1;
          state_nxt = ST_CLK_LO;
        end
      end
      ST_CLK_LO: begin
        controller_clk = 1'b0;
        if (phase_tc) state_nxt = ST_CLK_HI;
      end
      ST_CLK_HI: begin
        if (phase_tc) begin
          sample    = 1'b1;
          state_nxt = last_bit ? ST_DONE : ST_CLK_LO;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Phase timer reloads on every state change, so each state lasts load+1 cycles.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n)                   phase <= '0;
    else if (state_nxt != state)  phase <= (state_nxt == ST_LATCH) ? LATCH_LOAD : HALF_LOAD;
    else if (!phase_tc)           phase <= phase - 1'b1;
  end

  // Bits shift in from the top; after an NES frame the 8 bits sit in [15:8].
  assign raw_p1_nxt = {data_p1, raw_p1[SNES_BITS-1:1]};
  assign raw_p2_nxt = {data_p2, raw_p2[SNES_BITS-1:1]};

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      snes_q  <= 1'b0;
      bit_idx <= '0;
      raw_p1  <= '0;
      raw_p2  <= '0;
    end else if (frame_start) begin
      snes_q  <= is_snes;
      bit_idx <= '0;
      raw_p1  <= '0;
      raw_p2  <= '0;
    end else if (sample) begin
      bit_idx <= bit_idx + 1'b1;
      raw_p1  <= raw_p1_nxt;
      raw_p2  <= raw_p2_nxt;
    end
  end

  // Decode from the next-shift value so the words are ready in the DONE cycle
  // together with frame_valid. Upper bits are zero in NES mode, so the OR
  // covers exactly the N received bits.
  assign aligned_p1 = snes_q ? raw_p1_nxt
                             : {{(SNES_BITS-NES_BITS){1'b0}}, raw_p1_nxt[SNES_BITS-1 -: NES_BITS]};
  assign aligned_p2 = snes_q ? raw_p2_nxt
                             : {{(SNES_BITS-NES_BITS){1'b0}}, raw_p2_nxt[SNES_BITS-1 -: NES_BITS]};
  assign pres_p1 = |aligned_p1;
  assign pres_p2 = |aligned_p2;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      p1_buttons <= '0;
      p2_buttons <= '0;
      p1_present <= 1'b0;
      p2_present <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (state_nxt == ST_DONE) begin
        p1_present <= pres_p1;
        p2_present <= pres_p2;
        p1_buttons <= pres_p1 ? decode_frame(aligned_p1, snes_q) : '0;
        p2_buttons <= pres_p2 ? decode_frame(aligned_p2, snes_q) : '0;
      end
      if (tick && (state != ST_IDLE)) overrun <= 1'b1;
    end
  end

  assign frame_valid = (state == ST_DONE);
  assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_gamepad_poll_scheduler.sv
// Bench for gamepad_poll_scheduler. Four instances share clk_50:
//   u0 POLL_CYC=20000 : directed decode frames (NES, SNES, SNES upper buttons)
//   u1 POLL_CYC=20000 : reset mid-frame, then poll_en dropped mid-frame
//   u2 POLL_CYC=10000 : random frame type and pad patterns
//   u3 POLL_CYC=5000  : SNES frames longer than the poll period (overrun)
// A pad model per port loads a 16-bit pattern on latch and shifts on each
// rising serial clock; every frame_valid is checked against a reference
// decoder built from the button-order tables.
module tb_gamepad_poll_scheduler;

  localparam int NI = 4;

  logic clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  logic        rst_n [NI];
  logic        poll_en [NI];
  logic        is_snes [NI];
  logic        data_p1 [NI];
  logic        data_p2 [NI];
  logic        latch [NI];
  logic        cclk [NI];
  logic [11:0] p1_buttons [NI];
  logic [11:0] p2_buttons [NI];
  logic        p1_present [NI];
  logic        p2_present [NI];
  logic        frame_valid [NI];
  logic        busy [NI];
  logic        overrun [NI];

  logic [15:0] pat1 [NI];
  logic [15:0] pat2 [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int HZ = (g == 2) ? 5000 : (g == 3) ? 10000 : 2500;
    gamepad_poll_scheduler #(.CLK_HZ(50_000_000), .POLL_HZ(HZ), .HALF_CYC(300)) u_dut (
      .clk_50           (clk_50),
      .rst_n            (rst_n[g]),
      .poll_en          (poll_en[g]),
      .is_snes          (is_snes[g]),
      .data_p1          (data_p1[g]),
      .data_p2          (data_p2[g]),
      .controller_latch (latch[g]),
      .controller_clk   (cclk[g]),
      .p1_buttons       (p1_buttons[g]),
      .p2_buttons       (p2_buttons[g]),
      .p1_present       (p1_present[g]),
      .p2_present       (p2_present[g]),
      .frame_valid      (frame_valid[g]),
      .busy             (busy[g]),
      .overrun          (overrun[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Canonical index of each SNES serial bit: B,Y,Sel,Start,Up,Down,Left,Right,A,X,L,R.
  localparam int SNES_ORDER [12] = '{1, 9, 2, 3, 4, 5, 6, 7, 0, 8, 10, 11};

  // Returns {present, buttons} for a pad shifting out pat[0], pat[1], ...
  function automatic logic [12:0] expect_frame(input logic [15:0] pat, input logic snes);
    int          n;
    logic        present;
    logic [11:0] btn;
    n       = snes ? 16 : 8;
    present = 1'b0;
    btn     = '0;
    for (int k = 0; k < n; k++) if (pat[k]) present = 1'b1;
    for (int k = 0; k < n && k < 12; k++)
      if (!pat[k]) btn[snes ? SNES_ORDER[k] : k] = 1'b1;
    if (!present) btn = '0;
    return {present, btn};
  endfunction

  // Monitor / pad model state
  logic        prev_latch [NI] = '{default: 1'b0};
  logic        prev_clk [NI]   = '{default: 1'b1};
  logic        in_frame [NI]   = '{default: 1'b0};
  logic        cap_snes [NI]   = '{default: 1'b0};
  logic [15:0] cap1 [NI]       = '{default: 16'h0};
  logic [15:0] cap2 [NI]       = '{default: 16'h0};
  int          pad_idx [NI]    = '{default: 0};
  int          lat_cnt [NI]    = '{default: 0};
  int          latch_w [NI]    = '{default: 0};
  int          clk_falls [NI]  = '{default: 0};
  int          fv_cnt [NI]     = '{default: 0};
  int          latch_rises [NI] = '{default: 0};
  int          last_falls [NI] = '{default: 0};
  int          last_len [NI]   = '{default: 0};

  always @(negedge clk_50) begin : monitor
    logic [12:0] e1, e2;
    int n;
    for (int g = 0; g < NI; g++) begin
      if (!rst_n[g]) in_frame[g] = 1'b0;
      if (latch[g] && !prev_latch[g]) begin
        in_frame[g]  = 1'b1;
        lat_cnt[g]   = 0;
        latch_w[g]   = 0;
        clk_falls[g] = 0;
        cap_snes[g]  = is_snes[g];
        cap1[g]      = pat1[g];
        cap2[g]      = pat2[g];
        latch_rises[g]++;
      end else begin
        lat_cnt[g]++;
      end
      if (latch[g]) begin
        latch_w[g]++;
        pad_idx[g] = 0;
      end
      if (prev_clk[g] && !cclk[g]) clk_falls[g]++;
      if (!prev_clk[g] && cclk[g] && pad_idx[g] < 16) pad_idx[g]++;
      data_p1[g] = (pad_idx[g] < 16) ? cap1[g][pad_idx[g]] : 1'b0;
      data_p2[g] = (pad_idx[g] < 16) ? cap2[g][pad_idx[g]] : 1'b0;

      if (frame_valid[g] && in_frame[g]) begin
        n  = cap_snes[g] ? 16 : 8;
        e1 = expect_frame(cap1[g], cap_snes[g]);
        e2 = expect_frame(cap2[g], cap_snes[g]);
        chk($sformatf("u%0d p1_buttons", g), 32'(p1_buttons[g]), 32'(e1[11:0]));
        chk($sformatf("u%0d p2_buttons", g), 32'(p2_buttons[g]), 32'(e2[11:0]));
        chk($sformatf("u%0d p1_present", g), 32'(p1_present[g]), 32'(e1[12]));
        chk($sformatf("u%0d p2_present", g), 32'(p2_present[g]), 32'(e2[12]));
        chk($sformatf("u%0d frame_len", g), lat_cnt[g], cap_snes[g] ? 9900 : 5100);
        chk($sformatf("u%0d latch_width", g), latch_w[g], 600);
        chk($sformatf("u%0d clk_pulses", g), clk_falls[g], n - 1);
        last_falls[g] = clk_falls[g];
        last_len[g]   = lat_cnt[g];
        fv_cnt[g]++;
        in_frame[g] = 1'b0;
      end
      prev_latch[g] = latch[g];
      prev_clk[g]   = cclk[g];
    end
  end

  task automatic wait_fv(input int g, input int target, input int budget, input string tag);
    for (int c = 0; c < budget; c++) begin
      @(posedge clk_50); #1;
      if (fv_cnt[g] >= target) break;
    end
    chk(tag, 32'(fv_cnt[g] >= target), 32'd1);
  endtask

  function automatic logic [15:0] rand_pat();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic run_a();
    pat1[0] = 16'hFF7E; pat2[0] = 16'hFFFF; is_snes[0] = 1'b0;
    wait_fv(0, 1, 32000, "u0 nes frame_valid");
    chk("u0 nes p1_buttons", 32'(p1_buttons[0]), 32'h081);
    chk("u0 nes p1_present", 32'(p1_present[0]), 32'd1);
    chk("u0 nes p2_buttons", 32'(p2_buttons[0]), 32'h000);
    chk("u0 nes p2_present", 32'(p2_present[0]), 32'd1);
    chk("u0 nes clk_pulses", last_falls[0], 7);

    is_snes[0] = 1'b1; pat1[0] = 16'hFFFE; pat2[0] = 16'h0000;
    wait_fv(0, 2, 32000, "u0 snes frame_valid");
    chk("u0 snes p1_buttons", 32'(p1_buttons[0]), 32'h002);
    chk("u0 snes p2_present", 32'(p2_present[0]), 32'd0);
    chk("u0 snes p2_buttons", 32'(p2_buttons[0]), 32'h000);
    chk("u0 snes clk_pulses", last_falls[0], 15);
    chk("u0 snes frame_len", last_len[0], 9900);

    pat1[0] = 16'hF0FF; pat2[0] = 16'hFFFD;
    wait_fv(0, 3, 32000, "u0 snes hi frame_valid");
    chk("u0 snes A/X/L/R", 32'(p1_buttons[0]), 32'hD01);
    chk("u0 snes Y", 32'(p2_buttons[0]), 32'h200);
  endtask

  task automatic run_b();
    int  c;
    int  falls;
    int  rises;
    logic seen;
    logic prev;
    pat1[1] = 16'($urandom); pat2[1] = 16'($urandom); is_snes[1] = 1'b0;
    seen = 1'b0;
    for (c = 0; c < 25000; c++) begin
      @(posedge clk_50); #1;
      if (!cclk[1] && busy[1]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("u1 reached CLK_LO", 32'(seen), 32'd1);
    #3 rst_n[1] = 1'b0;
    #1;
    chk("u1 rst clk", 32'(cclk[1]), 32'd1);
    chk("u1 rst latch", 32'(latch[1]), 32'd0);
    chk("u1 rst busy", 32'(busy[1]), 32'd0);
    chk("u1 rst frame_valid", 32'(frame_valid[1]), 32'd0);
    chk("u1 rst buttons", 32'({p1_buttons[1], p2_buttons[1]}), 32'd0);
    chk("u1 rst present", 32'({p1_present[1], p2_present[1], overrun[1]}), 32'd0);
    repeat (5) @(posedge clk_50);
    #3 rst_n[1] = 1'b1;
    for (c = 1; c <= 20010; c++) begin
      @(posedge clk_50); #1;
      if (latch[1]) break;
    end
    chk("u1 first latch after reset", c, 20000);

    falls = 0;
    prev  = cclk[1];
    for (c = 0; c < 5000; c++) begin
      @(posedge clk_50); #1;
      if (prev && !cclk[1]) falls++;
      prev = cclk[1];
      if (falls == 3) break;
    end
    chk("u1 reached bit 3", falls, 3);
    poll_en[1] = 1'b0;
    wait_fv(1, 1, 10000, "u1 frame after poll_en drop");
    rises = latch_rises[1];
    repeat (22000) @(posedge clk_50);
    #1;
    chk("u1 no latch after poll_en drop", latch_rises[1], rises);
    chk("u1 idle after poll_en drop", 32'(busy[1]), 32'd0);
  endtask

  task automatic run_r();
    for (int f = 1; f <= 6; f++) begin
      is_snes[2] = 1'($urandom_range(0, 1));
      pat1[2] = rand_pat();
      pat2[2] = rand_pat();
      wait_fv(2, f, 22000, $sformatf("u2 random frame %0d", f));
    end
  endtask

  task automatic run_o();
    repeat (4000) @(posedge clk_50);
    #1 chk("u3 overrun before wrap", 32'(overrun[3]), 32'd0);
    repeat (8000) @(posedge clk_50);
    #1 chk("u3 overrun set", 32'(overrun[3]), 32'd1);
    repeat (18000) @(posedge clk_50);
    #1 chk("u3 overrun sticky", 32'(overrun[3]), 32'd1);
  endtask

  initial begin
    for (int g = 0; g < NI; g++) begin
      rst_n[g]   = 1'b0;
      poll_en[g] = 1'b1;
      is_snes[g] = 1'b0;
      pat1[g]    = 16'hFFFF;
      pat2[g]    = 16'hFFFF;
    end
    is_snes[3] = 1'b1;
    pat1[3]    = 16'hFF00;
    pat2[3]    = 16'h0FFF;
    repeat (3) @(posedge clk_50);
    #1;
    chk("reset latch", 32'(latch[0]), 32'd0);
    chk("reset clk", 32'(cclk[0]), 32'd1);
    chk("reset buttons", 32'({p1_buttons[0], p2_buttons[0]}), 32'd0);
    chk("reset present", 32'({p1_present[0], p2_present[0]}), 32'd0);
    chk("reset flags", 32'({frame_valid[0], busy[0], overrun[0]}), 32'd0);
    for (int g = 0; g < NI; g++) rst_n[g] = 1'b1;
    fork
      run_a();
      run_b();
      run_r();
      run_o();
    join
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
